// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared CPU definitions for the pipeline hazard/stall controller.
//   REG_AW      : register index width
//   WD_*        : writeback-select encodings carried down the pipe
//   ST_*        : controller state encodings
//   ctrl_t      : bundle of pipeline stall/flush controls
//   load_use_hit: load in EX feeding a source operand of the ID instruction
package hazard_stall_ctrl_pkg;

  localparam int unsigned REG_AW = 5;

  localparam logic [1:0] WD_ALU  = 2'b00;
  localparam logic [1:0] WD_LOAD = 2'b01;
  localparam logic [1:0] WD_PC4  = 2'b10;
  localparam logic [1:0] WD_IMM  = 2'b11;

  localparam logic ST_RUN      = 1'b0;
  localparam logic ST_MEM_WAIT = 1'b1;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_stall;
  } ctrl_t;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  function automatic logic load_use_hit(
    input logic [1:0]        ex_wdsel,
    input logic [REG_AW-1:0] ex_wr,
    input logic              ex_we,
    input logic [REG_AW-1:0] id_rr1,
    input logic              id_re1,
    input logic [REG_AW-1:0] id_rr2,
    input logic              id_re2
  );
    logic w_src_match;
    w_src_match = (id_re1 && (id_rr1 == ex_wr)) || (id_re2 && (id_rr2 == ex_wr));
    return ex_we && (ex_wdsel == WD_LOAD) && (ex_wr != REG_AW'(0)) && w_src_match;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle for hazard_stall_ctrl.
//   ID_* / EX_*      : operand and destination info from the ID and EX stages
//   dmem_req/ready   : data memory handshake of the MEM stage
//   *_stall/*_flush  : pipeline register controls returned by the controller
//   lu_cnt / mw_cnt  : load-use bubble and memory-wait performance counters
// master = pipeline (drives stage info), slave = controller.
interface hazard_stall_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import hazard_stall_ctrl_pkg::*;

  logic [REG_AW-1:0] ID_rR1;
  logic [REG_AW-1:0] ID_rR2;
  logic              ID_re1;
  logic              ID_re2;
  logic [1:0]        EX_WDSel;
  logic [REG_AW-1:0] EX_wR;
  logic              EX_we;
  logic              EX_br_taken;
  logic              dmem_req;
  logic              dmem_ready;
  logic              PC_stall;
  logic              IFID_stall;
  logic              IFID_flush;
  logic              IDEX_flush;
  logic              EXMEM_stall;
  logic [CNT_W-1:0]  lu_cnt;
  logic [CNT_W-1:0]  mw_cnt;

  modport master (
    output ID_rR1, ID_rR2, ID_re1, ID_re2,
    output EX_WDSel, EX_wR, EX_we, EX_br_taken,
    output dmem_req, dmem_ready,
    input  PC_stall, IFID_stall, IFID_flush, IDEX_flush, EXMEM_stall,
    input  lu_cnt, mw_cnt
  );

  modport slave (
    input  ID_rR1, ID_rR2, ID_re1, ID_re2,
    input  EX_WDSel, EX_wR, EX_we, EX_br_taken,
    input  dmem_req, dmem_ready,
    output PC_stall, IFID_stall, IFID_flush, IDEX_flush, EXMEM_stall,
    output lu_cnt, mw_cnt
  );

endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating event counter: counts cycles with inc high, sticks at all-ones.
//   clk, rst_n : clock and asynchronous active-low reset
//   inc        : count enable for this cycle
//   cnt        : current count
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / memory-wait stall controller for the 5-stage pipeline.
// Inserts one bubble for a load-use hazard, freezes the pipe while data
// memory is busy, and arbitrates branch flushes against both, replaying a
// flush that arrived on the cycle the freeze began.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : stage info in, stall/flush controls and perf counters out
// Controls are combinational (same-cycle response); only the state,
// the pending-flush flag and the counters are registered.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input logic                clk,
  input logic                rst_n,
  hazard_stall_ctrl_if.slave bus
);

  logic  r_state;
  logic  r_flush_pend;
  logic  w_state_nxt;
  logic  w_flush_pend_nxt;
  logic  w_lu_hit;
  logic  w_mw;
  logic  w_lu_inc;
  logic  w_mw_inc;
  ctrl_t w_ctrl;

  assign w_lu_hit = load_use_hit(bus.EX_WDSel, bus.EX_wR, bus.EX_we,
                                 bus.ID_rR1, bus.ID_re1, bus.ID_rR2, bus.ID_re2);
  assign w_mw     = bus.dmem_req && !bus.dmem_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      r_flush_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_pend <= w_flush_pend_nxt;
    end
  end

  // Next state; a taken branch seen on freeze entry is remembered for release.
  always_comb begin
    w_state_nxt      = r_state;
    w_flush_pend_nxt = r_flush_pend;
    case (r_state)
      ST_RUN: begin
        if (w_mw) begin
          w_state_nxt      = ST_MEM_WAIT;
          w_flush_pend_nxt = bus.EX_br_taken;
        end
      end
      ST_MEM_WAIT: begin
        if (!w_mw) begin
          w_state_nxt      = ST_RUN;
          w_flush_pend_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt      = ST_RUN;
        w_flush_pend_nxt = 1'b0;
      end
    endcase
  end

  // Pipeline controls and counter strobes; all forced low during reset.
  always_comb begin
    w_ctrl   = '0;
    w_lu_inc = 1'b0;
    w_mw_inc = 1'b0;
    if (rst_n) begin
      case (r_state)
        ST_RUN: begin
          if (w_mw) begin
            w_ctrl.pc_stall    = 1'b1;
            w_ctrl.ifid_stall  = 1'b1;
            w_ctrl.exmem_stall = 1'b1;
            w_mw_inc           = 1'b1;
          end else if (bus.EX_br_taken) begin
            // ID instruction is squashed, so a load-use hit is moot.
            w_ctrl.ifid_flush  = 1'b1;
            w_ctrl.idex_flush  = 1'b1;
          end else if (w_lu_hit) begin
            w_ctrl.pc_stall    = 1'b1;
            w_ctrl.ifid_stall  = 1'b1;
            w_ctrl.idex_flush  = 1'b1;
            w_lu_inc           = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (w_mw) begin
            w_ctrl.pc_stall    = 1'b1;
            w_ctrl.ifid_stall  = 1'b1;
            w_ctrl.exmem_stall = 1'b1;
            w_mw_inc           = 1'b1;
          end else if (r_flush_pend) begin
            w_ctrl.ifid_flush  = 1'b1;
            w_ctrl.idex_flush  = 1'b1;
          end else if (w_lu_hit) begin
            w_ctrl.pc_stall    = 1'b1;
            w_ctrl.ifid_stall  = 1'b1;
            w_ctrl.idex_flush  = 1'b1;
            w_lu_inc           = 1'b1;
          end
        end
        default: w_ctrl = '0;
      endcase
    end
  end

  assign bus.PC_stall    = w_ctrl.pc_stall;
  assign bus.IFID_stall  = w_ctrl.ifid_stall;
  assign bus.IFID_flush  = w_ctrl.ifid_flush;
  assign bus.IDEX_flush  = w_ctrl.idex_flush;
  assign bus.EXMEM_stall = w_ctrl.exmem_stall;

  sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_lu_inc),
    .cnt   (bus.lu_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mw_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_mw_inc),
    .cnt   (bus.mw_cnt)
  );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios followed by
// random stimulus against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  // Output vector order: {PC_stall, IFID_stall, IFID_flush, IDEX_flush, EXMEM_stall}
  localparam logic [4:0] O_NONE   = 5'b00000;
  localparam logic [4:0] O_FREEZE = 5'b11001;
  localparam logic [4:0] O_FLUSH  = 5'b00110;
  localparam logic [4:0] O_BUBBLE = 5'b11010;

  logic clk;
  logic rst_n;

  hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_stall_ctrl #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Model: whether the pipe is frozen, whether a branch flush is owed, counts.
  bit m_frozen;
  bit m_owed;
  int m_lu;
  int m_mw;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] dut_out();
    return {bus.PC_stall, bus.IFID_stall, bus.IFID_flush, bus.IDEX_flush, bus.EXMEM_stall};
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic model_reset();
    m_frozen = 1'b0;
    m_owed   = 1'b0;
    m_lu     = 0;
    m_mw     = 0;
  endtask

  // Evaluate the current inputs: expected controls now and model state after the edge.
  task automatic model_eval(output logic [4:0] exp, output bit nf, output bit no,
                            output int nlu, output int nmw);
    bit hazard;
    bit busy;
    hazard = bus.EX_we && (bus.EX_WDSel == 2'b01) && (bus.EX_wR != 0) &&
             ((bus.ID_re1 && bus.ID_rR1 == bus.EX_wR) || (bus.ID_re2 && bus.ID_rR2 == bus.EX_wR));
    busy   = bus.dmem_req && !bus.dmem_ready;
    exp = O_NONE;
    nf  = m_frozen;
    no  = m_owed;
    nlu = m_lu;
    nmw = m_mw;
    if (busy) begin
      exp = O_FREEZE;
      nmw = sat_inc(m_mw);
      if (!m_frozen) begin
        nf = 1'b1;
        no = bus.EX_br_taken;
      end
    end else if (m_frozen) begin
      nf = 1'b0;
      no = 1'b0;
      if (m_owed) exp = O_FLUSH;
      else if (hazard) begin
        exp = O_BUBBLE;
        nlu = sat_inc(m_lu);
      end
    end else if (bus.EX_br_taken) begin
      exp = O_FLUSH;
    end else if (hazard) begin
      exp = O_BUBBLE;
      nlu = sat_inc(m_lu);
    end
  endtask

  // One pipeline cycle: inputs are already driven (just after a posedge).
  task automatic cyc(input string tag);
    logic [4:0] exp;
    bit nf, no;
    int nlu, nmw;
    #1;
    model_eval(exp, nf, no, nlu, nmw);
    check({tag, "/ctrl"}, 32'(dut_out()), 32'(exp));
    @(posedge clk);
    #1;
    m_frozen = nf;
    m_owed   = no;
    m_lu     = nlu;
    m_mw     = nmw;
    check({tag, "/lu_cnt"}, 32'(bus.lu_cnt), 32'(m_lu));
    check({tag, "/mw_cnt"}, 32'(bus.mw_cnt), 32'(m_mw));
  endtask

  task automatic drive_idle();
    bus.ID_rR1      = '0;
    bus.ID_rR2      = '0;
    bus.ID_re1      = 1'b0;
    bus.ID_re2      = 1'b0;
    bus.EX_WDSel    = 2'b00;
    bus.EX_wR       = '0;
    bus.EX_we       = 1'b0;
    bus.EX_br_taken = 1'b0;
    bus.dmem_req    = 1'b0;
    bus.dmem_ready  = 1'b0;
  endtask

  // lw x5 in EX, consumer in ID reading x5 through rR1.
  task automatic drive_lw5_use();
    drive_idle();
    bus.EX_WDSel = 2'b01;
    bus.EX_wR    = 5'd5;
    bus.EX_we    = 1'b1;
    bus.ID_rR1   = 5'd5;
    bus.ID_re1   = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();

    // Reset state: controls held low even with a busy memory request.
    rst_n = 1'b0;
    drive_idle();
    bus.dmem_req = 1'b1;
    #3;
    check("reset/ctrl", 32'(dut_out()), 32'(O_NONE));
    check("reset/lu_cnt", 32'(bus.lu_cnt), 32'd0);
    check("reset/mw_cnt", 32'(bus.mw_cnt), 32'd0);
    drive_idle();
    do_reset();

    // Load-use on rR1, then the bubble in EX clears the hazard.
    drive_lw5_use();
    cyc("lu_rr1");
    check("lu_rr1/cnt1", 32'(bus.lu_cnt), 32'd1);
    drive_idle();
    bus.ID_rR1 = 5'd5;
    bus.ID_re1 = 1'b1;
    cyc("lu_after_bubble");

    // Load into x0, and rR2 match without read enable: no hazard.
    drive_lw5_use();
    bus.EX_wR  = 5'd0;
    bus.ID_rR1 = 5'd0;
    cyc("lu_x0");
    drive_lw5_use();
    bus.ID_re1 = 1'b0;
    bus.ID_rR1 = 5'd3;
    bus.ID_rR2 = 5'd5;
    cyc("lu_rr2_noread");
    bus.ID_re2 = 1'b1;
    cyc("lu_rr2_read");

    // Branch beats load-use.
    drive_lw5_use();
    bus.EX_br_taken = 1'b1;
    cyc("br_over_lu");

    // Three-cycle freeze with a branch on entry; flush replayed at release.
    drive_idle();
    do_reset();
    drive_lw5_use();
    bus.EX_br_taken = 1'b1;
    bus.dmem_req    = 1'b1;
    cyc("mw_1");
    cyc("mw_2");
    cyc("mw_3");
    check("mw/cnt3", 32'(bus.mw_cnt), 32'd3);
    bus.dmem_ready = 1'b1;
    cyc("mw_release");
    drive_idle();
    cyc("mw_after");

    // Saturation of the load-use counter.
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      drive_lw5_use();
      cyc("lu_sat");
    end
    check("lu_sat/allones", 32'(bus.lu_cnt), 32'(CNT_MAX));

    // Asynchronous reset in the middle of a freeze that owes a flush.
    drive_idle();
    do_reset();
    bus.EX_br_taken = 1'b1;
    bus.dmem_req    = 1'b1;
    cyc("rst_mid_enter");
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid/ctrl", 32'(dut_out()), 32'(O_NONE));
    check("rst_mid/mw_cnt", 32'(bus.mw_cnt), 32'd0);
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive_idle();
    @(posedge clk);
    #1;
    cyc("rst_mid_noflush");
    bus.ID_re1 = 1'b1;
    bus.dmem_ready = 1'b1;
    cyc("rst_mid_ready_noflush");

    // Random traffic; while frozen the upstream stages hold their values.
    drive_idle();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (!m_frozen) begin
        bus.ID_rR1      = 5'($urandom_range(0, 5));
        bus.ID_rR2      = 5'($urandom_range(0, 5));
        bus.ID_re1      = 1'($urandom_range(0, 1));
        bus.ID_re2      = 1'($urandom_range(0, 1));
        bus.EX_WDSel    = 2'($urandom_range(0, 3));
        bus.EX_wR       = 5'($urandom_range(0, 5));
        bus.EX_we       = ($urandom_range(0, 3) != 0);
        bus.EX_br_taken = ($urandom_range(0, 7) == 0);
        bus.dmem_req    = ($urandom_range(0, 2) == 0);
        bus.dmem_ready  = 1'($urandom_range(0, 1));
      end else begin
        bus.dmem_req   = 1'b1;
        bus.dmem_ready = ($urandom_range(0, 2) == 0);
      end
      cyc("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
